// File: rtl/freq_div_pkg.sv
// Shared encodings for the programmable clock divider: FSM states, output
// modes and the smallest ratio the divider accepts.
package freq_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

    localparam logic MODE_DUTY50 = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int unsigned RATIO_MIN = 2;

endpackage

// File: rtl/freq_div_core.sv
// Period counter and registered divider outputs. The active ratio/mode are
// only replaced when the controller asks for it, at a period boundary or while parked.
module freq_div_core
    import freq_div_pkg::*;
#(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned DEFAULT_RATIO = 2,
    parameter logic        DEFAULT_MODE  = MODE_DUTY50
) (
    input  logic             inClk,
    input  logic             reset,
    input  logic             park_i,
    input  logic             apply_i,
    input  logic [CNT_W-1:0] new_ratio_i,
    input  logic             new_mode_i,
    output logic             wrap_o,
    output logic             out_clk_o,
    output logic             out_pulse_o
);

    localparam int unsigned      EXT_W     = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [EXT_W-1:0] EXT_ONE   = EXT_W'(1);
    localparam logic [CNT_W-1:0] RST_RATIO = CNT_W'(DEFAULT_RATIO);

    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_clk_q, out_clk_d;
    logic             out_pulse_q, out_pulse_d;
    logic [EXT_W-1:0] ratio_ext;
    logic [EXT_W-1:0] high_d;

    assign wrap_o = (cnt_q == ratio_q - CNT_ONE);

    always_comb begin
        // NOTE: every combinational output is given a default first so no
        // path through the block leaves it unassigned (which would infer a latch).
        ratio_d = ratio_q;
        mode_d  = mode_q;
        if (apply_i) begin
            ratio_d = new_ratio_i;
            mode_d  = new_mode_i;
        end
    end

    // High time uses one extra bit so (N+1) cannot overflow at the largest N.
    always_comb begin
        ratio_ext = {1'b0, ratio_d};
        high_d    = (mode_d == MODE_PULSE) ? EXT_ONE : ((ratio_ext + EXT_ONE) >> 1);
    end

    always_comb begin
        cnt_d       = cnt_q;
        out_clk_d   = 1'b0;
        out_pulse_d = 1'b0;
        if (park_i) begin
            cnt_d = ratio_d - CNT_ONE;
        end else begin
            cnt_d       = wrap_o ? '0 : cnt_q + CNT_ONE;
            out_clk_d   = ({1'b0, cnt_d} < high_d);
            out_pulse_d = (cnt_d == '0);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their next values from the same pre-edge snapshot.
    always_ff @(posedge inClk or posedge reset) begin
        if (reset) begin
            ratio_q     <= RST_RATIO;
            mode_q      <= DEFAULT_MODE;
            cnt_q       <= RST_RATIO - CNT_ONE;
            out_clk_q   <= 1'b0;
            out_pulse_q <= 1'b0;
        end else begin
            ratio_q     <= ratio_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            out_clk_q   <= out_clk_d;
            out_pulse_q <= out_pulse_d;
        end
    end

    assign out_clk_o   = out_clk_q;
    assign out_pulse_o = out_pulse_q;

endmodule

// File: rtl/freq_divider_prog.sv
// Programmable integer clock divider: run/stop state machine, single-entry
// config buffer behind a valid/ready port, and the counter core.
module freq_divider_prog
    import freq_div_pkg::*;
#(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned DEFAULT_RATIO = 2,
    parameter logic        DEFAULT_MODE  = MODE_DUTY50
) (
    input  logic             inClk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_ratio,
    input  logic             cfg_mode,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             outClk,
    output logic             outPulse,
    output logic             busy
);

    localparam logic [CNT_W-1:0] RATIO_MIN_C = CNT_W'(RATIO_MIN);

    state_e           state_q, state_d;
    logic             pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0] pend_ratio_q, pend_ratio_d;
    logic             pend_mode_q, pend_mode_d;
    logic             cfg_err_q, cfg_err_d;

    logic wrap;
    logic park;
    logic apply;
    logic cfg_fire;
    logic cfg_legal;

    assign cfg_ready = !pend_valid_q;
    assign cfg_fire  = cfg_valid & cfg_ready;
    assign cfg_legal = (cfg_ratio >= RATIO_MIN_C);

    // A parked divider takes new settings at once; a running one only at a wrap.
    assign apply = pend_valid_q & ((state_q == ST_IDLE) | wrap);

    always_comb begin
        state_d = state_q;
        park    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                park = 1'b1;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    // A ratio change landing on this wrap still gets its full period.
                    if (wrap && !pend_valid_q) begin
                        state_d = ST_IDLE;
                        park    = 1'b1;
                    end else begin
                        state_d = ST_STOPPING;
                    end
                end
            end
            ST_STOPPING: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (wrap) begin
                    state_d = ST_IDLE;
                    park    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                park    = 1'b1;
            end
        endcase
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_ratio_d = pend_ratio_q;
        pend_mode_d  = pend_mode_q;
        cfg_err_d    = 1'b0;
        if (apply) begin
            pend_valid_d = 1'b0;
        end
        if (cfg_fire) begin
            if (cfg_legal) begin
                pend_valid_d = 1'b1;
                pend_ratio_d = cfg_ratio;
                pend_mode_d  = cfg_mode;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge inClk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pend_valid_q <= 1'b0;
            pend_ratio_q <= '0;
            pend_mode_q  <= MODE_DUTY50;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_ratio_q <= pend_ratio_d;
            pend_mode_q  <= pend_mode_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;
    assign busy    = (state_q != ST_IDLE);

    freq_div_core #(
        .CNT_W         (CNT_W),
        .DEFAULT_RATIO (DEFAULT_RATIO),
        .DEFAULT_MODE  (DEFAULT_MODE)
    ) u_core (
        .inClk       (inClk),
        .reset       (reset),
        .park_i      (park),
        .apply_i     (apply),
        .new_ratio_i (pend_ratio_q),
        .new_mode_i  (pend_mode_q),
        .wrap_o      (wrap),
        .out_clk_o   (outClk),
        .out_pulse_o (outPulse)
    );

endmodule

// File: tb/tb_freq_divider_prog.sv
// Self-checking bench for freq_divider_prog: per-cycle vector tables with a
// scoreboard queue, plus hand-written reset sequences.
module tb_freq_divider_prog;

    localparam int CNT_W = 16;

    logic             inClk = 1'b0;
    logic             reset;
    logic             enable;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_ratio;
    logic             cfg_mode;
    logic             cfg_ready;
    logic             cfg_err;
    logic             outClk;
    logic             outPulse;
    logic             busy;

    always #5 inClk = ~inClk;

    freq_divider_prog #(
        .CNT_W         (CNT_W),
        .DEFAULT_RATIO (2),
        .DEFAULT_MODE  (1'b0)
    ) dut (
        .inClk     (inClk),
        .reset     (reset),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ratio (cfg_ratio),
        .cfg_mode  (cfg_mode),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .outClk    (outClk),
        .outPulse  (outPulse),
        .busy      (busy)
    );

    // Expected outputs after the edge, packed as {outClk, outPulse, busy, cfg_ready, cfg_err}.
    typedef logic [4:0] exp_t;

    typedef struct {
        logic             en;
        logic             v;
        logic [CNT_W-1:0] ratio;
        logic             mode;
        exp_t             exp;
    } vec_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic add(input logic en, input logic v, input int r, input logic m, input exp_t e);
        vec_t x;
        x.en    = en;
        x.v     = v;
        x.ratio = CNT_W'(r);
        x.mode  = m;
        x.exp   = e;
        tbl.push_back(x);
    endtask

    task automatic addn(input int n, input logic en, input exp_t e);
        for (int k = 0; k < n; k++) add(en, 1'b0, 0, 1'b0, e);
    endtask

    task automatic run_table(input string tag);
        exp_t want;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge inClk);
            enable    = tbl[i].en;
            cfg_valid = tbl[i].v;
            cfg_ratio = tbl[i].ratio;
            cfg_mode  = tbl[i].mode;
            sb_q.push_back(tbl[i].exp);
            @(posedge inClk);
            #1;
            want = sb_q.pop_front();
            check($sformatf("%s[%0d] {clk,pulse,busy,rdy,err}", tag, i),
                  32'({outClk, outPulse, busy, cfg_ready, cfg_err}), 32'(want));
        end
        tbl.delete();
        @(negedge inClk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_ratio = '0;
        cfg_mode  = 1'b0;

        repeat (2) @(negedge inClk);
        check("reset_outputs", 32'({outClk, outPulse, busy, cfg_ready, cfg_err}), 32'(5'b00010));
        reset = 1'b0;

        // Defaults N=2: first rise one cycle after enable is sampled, then stop.
        addn(1, 1'b1, 5'b00110);
        add(1, 0, 0, 0, 5'b11110);
        add(1, 0, 0, 0, 5'b00110);
        add(1, 0, 0, 0, 5'b11110);
        add(1, 0, 0, 0, 5'b00110);
        add(1, 0, 0, 0, 5'b11110);
        add(0, 0, 0, 0, 5'b00110);
        add(0, 0, 0, 0, 5'b00010);
        run_table("default_n2");

        // The trailing idle cycle from run_table keeps IDLE; load N=5 and run.
        add(0, 1, 5, 0, 5'b00000);
        add(0, 0, 0, 0, 5'b00010);
        add(1, 0, 0, 0, 5'b00110);
        for (int p = 0; p < 2; p++) begin
            add(1, 0, 0, 0, 5'b11110);
            add(1, 0, 0, 0, 5'b10110);
            add(1, 0, 0, 0, 5'b10110);
            add(1, 0, 0, 0, 5'b00110);
            add(1, 0, 0, 0, 5'b00110);
        end
        // Offer N=4 on the wrap edge: it lands at the following wrap.
        add(1, 1, 4, 0, 5'b11100);
        add(1, 0, 0, 0, 5'b10100);
        add(1, 0, 0, 0, 5'b10100);
        add(1, 0, 0, 0, 5'b00100);
        add(1, 0, 0, 0, 5'b00100);
        add(1, 0, 0, 0, 5'b11110);
        // Running N=4: illegal ratio 1, then N=6 mid-period.
        add(1, 1, 1, 0, 5'b10111);
        add(1, 1, 6, 0, 5'b00100);
        add(1, 0, 0, 0, 5'b00100);
        add(1, 0, 0, 0, 5'b11110);
        add(1, 0, 0, 0, 5'b10110);
        add(1, 0, 0, 0, 5'b10110);
        add(1, 0, 0, 0, 5'b00110);
        add(1, 0, 0, 0, 5'b00110);
        add(1, 0, 0, 0, 5'b00110);
        add(1, 0, 0, 0, 5'b11110);
        run_table("ratio_change");

        // The run_table boundary adds a cycle with enable still high: cnt=1 of N=6.
        add(1, 1, 7, 1, 5'b10100);
        add(1, 0, 0, 0, 5'b00100);
        add(1, 0, 0, 0, 5'b00100);
        add(1, 0, 0, 0, 5'b00100);
        add(1, 0, 0, 0, 5'b11110);
        add(1, 0, 0, 0, 5'b00110);
        add(1, 0, 0, 0, 5'b00110);
        // Drop enable at cnt=2 of N=7 pulse mode.
        addn(4, 1'b0, 5'b00110);
        addn(1, 1'b0, 5'b00010);
        addn(1, 1'b1, 5'b00110);
        addn(1, 1'b1, 5'b11110);
        addn(6, 1'b1, 5'b00110);
        addn(1, 1'b1, 5'b11110);
        // Brief stop request withdrawn while STOPPING: no discontinuity.
        addn(1, 1'b0, 5'b00110);
        addn(5, 1'b1, 5'b00110);
        addn(1, 1'b1, 5'b11110);
        // Enable low exactly at the wrap: straight to IDLE.
        addn(6, 1'b1, 5'b00110);
        addn(1, 1'b0, 5'b00010);
        // Enable falls on the edge that applies N=3: new period runs, then stop.
        addn(1, 1'b1, 5'b00110);
        addn(1, 1'b1, 5'b11110);
        add(1, 1, 3, 0, 5'b00100);
        addn(5, 1'b1, 5'b00100);
        addn(1, 1'b0, 5'b11110);
        addn(1, 1'b0, 5'b10110);
        addn(1, 1'b0, 5'b00110);
        addn(1, 1'b0, 5'b00010);
        run_table("stop_restart");

        // Load N=9, run a few cycles, then reset asynchronously mid-cycle.
        @(negedge inClk);
        cfg_valid = 1'b1;
        cfg_ratio = CNT_W'(9);
        cfg_mode  = 1'b0;
        @(negedge inClk);
        cfg_valid = 1'b0;
        enable    = 1'b1;
        repeat (4) @(negedge inClk);
        check("n9_running_clk", 32'(outClk), 32'(1));
        check("n9_running_busy", 32'(busy), 32'(1));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 32'({outClk, outPulse, busy, cfg_ready, cfg_err}), 32'(5'b00010));
        @(negedge inClk);
        check("held_reset_outputs", 32'({outClk, outPulse, busy, cfg_ready, cfg_err}), 32'(5'b00010));
        reset  = 1'b0;
        enable = 1'b0;

        addn(1, 1'b1, 5'b00110);
        addn(1, 1'b1, 5'b11110);
        addn(1, 1'b1, 5'b00110);
        addn(1, 1'b1, 5'b11110);
        addn(1, 1'b0, 5'b00110);
        addn(1, 1'b0, 5'b00010);
        run_table("after_reset_n2");

        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_divider_prog.md
Name: freq_divider_prog

Overview:
- Programmable integer clock divider, the successor to the fixed power-of-two divider.
- Divides inClk by any N in [2, 2^CNT_W-1], with a 50%-duty or single-pulse output mode.
- Ratio changes and start/stop are glitch-free, applied only at output-period boundaries.
- Drives derived clock-enables and strobes for peripheral blocks; new ratios come from a valid/ready config port.

Parameters:
- CNT_W, 16: width of the ratio and period counter.
- DEFAULT_RATIO, 2: active ratio after reset; legal range 2..2^CNT_W-1.
- DEFAULT_MODE, 0: active mode after reset; 0 = 50% duty, 1 = pulse.

Ports:
- inClk  in  1  input clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request (level).
- cfg_valid  in  1  config offer.
- cfg_ratio  in  CNT_W  requested divide ratio N.
- cfg_mode  in  1  requested mode.
- cfg_ready  out  1  config accept; handshake completes when cfg_valid & cfg_ready.
- cfg_err  out  1  1-cycle pulse: accepted config was illegal and discarded.
- outClk  out  1  divided output, registered.
- outPulse  out  1  1-cycle strobe at each period start, registered.
- busy  out  1  high in RUN or STOPPING.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; active N=DEFAULT_RATIO, mode=DEFAULT_MODE; cnt=N-1; pending empty.
  - outClk=0, outPulse=0, cfg_ready=1, cfg_err=0, busy=0.
  - Reset asserted mid-operation aborts immediately; outputs go to reset values with no completion of the current period.
- Counter:
  - In RUN/STOPPING, each edge: cnt <= (cnt==N-1) ? 0 : cnt+1.
  - Wrap to 0 is the period boundary.
- High time H: mode 0 -> H=(N+1)>>1 (odd N: one extra high cycle); mode 1 -> H=1.
- Outputs, registered from the next counter value:
  - outClk <= (cnt_next < H).
  - outPulse <= (cnt_next == 0).
  - In mode 1, outClk equals outPulse.
- States:
  - IDLE: cnt held at N-1; outClk=0. enable=1 -> RUN. The first RUN edge wraps cnt to 0, so outClk and outPulse rise one cycle after enable is sampled high, giving a full first period.
  - RUN: count. enable=0 -> STOPPING, but only if cnt != N-1; otherwise go directly to IDLE and apply no new period.
  - STOPPING: keep counting; on the edge where cnt==N-1 would wrap, go to IDLE with cnt=N-1 and outClk=0. enable=1 while STOPPING -> back to RUN with no discontinuity.
- Config path:
  - cfg_ready = !pending_valid. An accepted config is stored in pending.
  - In IDLE, pending is applied on the next edge: N and mode are loaded and cnt=new N-1.
  - In RUN/STOPPING, pending is applied on the edge where cnt wraps (cnt==N-1). That edge already uses the new N/H to compute outputs, so the new period starts at cnt=0 with the new high time.
  - Pending is cleared on apply; cfg_ready returns to 1 the cycle after apply.
- Illegal ratio (cfg_ratio < 2):
  - The handshake completes, pending is not written, cfg_err pulses on the cycle after acceptance, and active config is unchanged.
- Simultaneous events:
  - Config accepted on the same edge as a wrap: it is applied at the following wrap, not this one.
  - enable falls on the same edge as a pending apply: apply happens, then stop at the end of the new period.
- Legacy equivalence: N=2^(k+1), mode 0 reproduces the old counter[k] output (50% duty, period 2^(k+1)).

Decomposition:
- Package freq_div_pkg:
  - state encoding constants ST_IDLE, ST_RUN, ST_STOPPING.
  - mode constants MODE_DUTY50=0, MODE_PULSE=1.
  - minimum legal ratio constant RATIO_MIN=2.
- Sub-module freq_div_core: counter, H computation, outClk/outPulse registers, apply-at-wrap load.
- Top level: state machine, config handshake, pending buffer, cfg_err.

Test Plan:
- Reset, then enable=1 with defaults -> outClk toggles every cycle (period 2); outPulse high each rising edge; first rise 1 cycle after enable sampled.
- Config N=5, mode 0, then run -> outClk pattern 1,1,1,0,0 repeating; outPulse once per 5 cycles; busy=1.
- Running N=4; load N=6 mid-period -> current period completes as 1,1,0,0, next is 1,1,1,0,0,0; cfg_ready low until the apply edge +1.
- N=7 mode 1; drop enable at cnt=2 -> remaining 4 cycles outClk=0 with no pulse, IDLE, busy=0; re-enable restarts with a full period.
- Offer cfg_ratio=1 while running N=4 -> cfg_err 1-cycle pulse; period stays 4; cfg_ready stays 1.
- Assert reset mid-period with N=9 -> outClk=0 and busy=0 immediately; after release, enable gives period 2 (DEFAULT_RATIO).
